mem_xlat_arb: RTL
=================

# mem_xlat_arb

Two-requester memory arbiter and translation sequencer for the noop core. Shares one fixed-mapping address translation path and one physical memory port between instruction fetch (I) and data access (D). Grants one request at a time, translates its virtual address, drives the memory handshake and returns the response to the owning requester. Sits between the pipeline's IF/MEM stages and the external memory interface.

## Interface
- `ADDR_W`, 32: virtual and physical address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `i_req_valid` / `d_req_valid` in 1: request present.
- `i_req_ready` / `d_req_ready` out 1: request accepted this cycle when valid&ready.
- `i_req_addr` / `d_req_addr` in ADDR_W: virtual address.
- `d_req_wen` in 1: write (D only; I is read-only).
- `d_req_wstrb` in DATA_W/8: byte enables for the write.
- `d_req_wdata` in DATA_W: write data.
- `i_resp_valid` / `d_resp_valid` out 1: one-cycle response pulse.
- `i_resp_rdata` / `d_resp_rdata` out DATA_W: read data, valid with the pulse.
- `mem_valid` out 1, `mem_ready` in 1: physical request handshake.
- `mem_addr` out ADDR_W: translated physical address.
- `mem_wen` out 1, `mem_wstrb` out DATA_W/8, `mem_wdata` out DATA_W.
- `mem_resp_valid` in 1, `mem_rdata` in DATA_W: memory response.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one transaction is outstanding.
- IDLE: `x_req_ready` is high only for the requester being granted this cycle. On acceptance, latch the owner, translated address, wen, wstrb and wdata; go to ISSUE.
- Grant: see Configuration. If exactly one requester is valid, it is granted.
- Translation of vaddr `v` (registered at acceptance):
  - `v < 0x8000_0000` (kuseg): `v`.
  - `0x8000_0000..0x9FFF_FFFF` (kseg0): `v & 0x1FFF_FFFF`.
  - `0xA000_0000..0xBFFF_FFFF` (kseg1): `v & 0x1FFF_FFFF`.
  - `>= 0xC000_0000` (kseg2/3): `v`.
- ISSUE: `mem_valid`=1 with stable latched fields until `mem_ready`; then go to WAIT. `mem_resp_valid` in the same cycle as the `mem_ready` handshake is also accepted (go straight to RESP).
- WAIT: on `mem_resp_valid`, capture `mem_rdata`; go to RESP.
- RESP: pulse owner's `resp_valid` for exactly one cycle with captured data; the other requester's `resp_valid` stays 0. Return to IDLE.
- Writes also produce a response pulse (rdata = whatever the memory returns); the requester uses it as a write ack.
- `mem_resp_valid` outside ISSUE/WAIT is ignored.
- Requester drops valid without handshake: no effect; nothing is latched.

## Timing
- Reset (`resetn`=0 at a rising edge): state IDLE; all `*_ready`, `*_resp_valid`, `mem_valid`, `mem_wen` = 0; `mem_addr`, `mem_wstrb`, `mem_wdata`, `*_resp_rdata` = 0; round-robin pointer = I. Reset mid-transaction abandons it with no response pulse.
- Outputs are registered except `x_req_ready`, which is combinational from state and the valid inputs.
- Best-case latency: accept at cycle N; `mem_valid` at N+1; `mem_ready` plus `mem_resp_valid` at N+1 gives `resp_valid` at N+2; next acceptance at N+3.
- Throughput is at most one transaction per 3 cycles.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous I+D request, grant the requester that was not granted last. The pointer updates only on acceptance.
- `MEM_ARB_RR_EN` undefined: fixed priority, D over I. I can starve while D keeps requesting.

## Test plan
- Single I read at vaddr `0xBFC0_0000`: `mem_addr`=`0x1FC0_0000` on cycle N+1. With `mem_rdata`=`0x2408_0001` returned immediately, `i_resp_valid` pulses at N+2 with that data; `d_resp_valid` stays 0.
- D write to `0x8000_1004`, wstrb `4'b0011`, wdata `0xDEAD_BEEF`, with `mem_ready` delayed 3 cycles: fields stay stable through the stall; `mem_addr`=`0x0000_1004`; `d_resp_valid` is one pulse.
- Simultaneous I and D valid for 4 transactions:
  - With RR: grants alternate D, I, D, I when the last grant was I.
  - Without RR: grants are all D.
- Passthrough segments: vaddr `0x0040_0000` maps to `0x0040_0000`, and `0xC000_0010` maps to `0xC000_0010`.
- Assert `resetn`=0 during WAIT, then fire `mem_resp_valid`: no `resp_valid` pulse; all outputs are 0; state is IDLE.
- Spurious `mem_resp_valid` while IDLE: no response pulse, no state change.

Source files
------------

// File: rtl/mem_xlat_arb_if.sv
// mem_xlat_arb_if: bundle of the two requester channels (I fetch, D access)
// and the physical memory port served by mem_xlat_arb.
//
// Handshake rules (all channels):
//   A request transfers on a rising edge where valid & ready are both high.
//   A requester may drop valid before ready; nothing is then captured.
//   resp_valid is a single-cycle pulse with rdata valid in that cycle.
//   mem_valid is held, with stable fields, until mem_ready is seen.
//   mem_resp_valid is only honoured while a transaction is outstanding.
//
// Modports:
//   slave  - the arbiter (takes requests, drives the memory port)
//   master - the environment (requesters plus memory model)
interface mem_xlat_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_rdata;

  logic                d_req_valid;
  logic                d_req_ready;
  logic [ADDR_W-1:0]   d_req_addr;
  logic                d_req_wen;
  logic [DATA_W/8-1:0] d_req_wstrb;
  logic [DATA_W-1:0]   d_req_wdata;
  logic                d_resp_valid;
  logic [DATA_W-1:0]   d_resp_rdata;

  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_rdata,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wstrb, d_req_wdata,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    input  mem_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_rdata,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wstrb, d_req_wdata,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    output mem_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_xlat_arb.sv
// mem_xlat_arb: shares one fixed-mapping translation path and one memory
// port between instruction fetch (I) and data access (D). One transaction
// is outstanding at a time: IDLE (grant) -> ISSUE (mem handshake) ->
// WAIT (memory response) -> RESP (one-cycle pulse to the owner).
//
// Ports:
//   clk       - rising-edge clock
//   resetn    - synchronous active-low reset
//   bus       - mem_xlat_arb_if.slave: I/D request+response, memory port
//   dbg_state - current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Build option:
//   MEM_ARB_RR_EN defined   -> round-robin between I and D on contention
//   MEM_ARB_RR_EN undefined -> fixed priority, D over I
module mem_xlat_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  mem_xlat_arb_if.slave       bus,
  output logic [1:0]          dbg_state
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_d_q, owner_d_d;   // 1 = D owns the transaction
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wen_q, mem_wen_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;
  logic                grant_i, grant_d;

  // kseg0/kseg1 (top two bits 2'b10) drop their top three bits; every
  // other segment passes through untouched.
  function automatic logic [ADDR_W-1:0] xlat(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] p;
    p = v;
    if (v[ADDR_W-1 -: 2] == 2'b10) p[ADDR_W-1 -: 3] = 3'b000;
    return p;
  endfunction

`ifdef MEM_ARB_RR_EN
  // Remembers the last accepted requester; reset value means "I".
  logic last_d_q, last_d_d;
  assign grant_d = bus.d_req_valid & (~bus.i_req_valid | ~last_d_q);
`else
  assign grant_d = bus.d_req_valid;
`endif
  assign grant_i = bus.i_req_valid & ~grant_d;

  // Ready is the only combinational output: offered in IDLE to the winner.
  assign bus.i_req_ready = (state_q == IDLE) & grant_i;
  assign bus.d_req_ready = (state_q == IDLE) & grant_d;

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_i | grant_d) begin
          owner_d_d   = grant_d;
          mem_addr_d  = xlat(grant_d ? bus.d_req_addr : bus.i_req_addr);
          mem_wen_d   = grant_d & bus.d_req_wen;
          mem_wstrb_d = grant_d ? bus.d_req_wstrb : '0;
          mem_wdata_d = grant_d ? bus.d_req_wdata : '0;
          mem_valid_d = 1'b1;
          state_d     = ISSUE;
`ifdef MEM_ARB_RR_EN
          last_d_d    = grant_d;
`endif
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          // A response arriving with the handshake skips WAIT.
          if (bus.mem_resp_valid) begin
            rdata_d  = bus.mem_rdata;
            i_resp_d = ~owner_d_q;
            d_resp_d = owner_d_q;
            state_d  = RESP;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          rdata_d  = bus.mem_rdata;
          i_resp_d = ~owner_d_q;
          d_resp_d = owner_d_q;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wen      = mem_wen_q;
  assign bus.mem_wstrb    = mem_wstrb_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.i_resp_valid = i_resp_q;
  assign bus.d_resp_valid = d_resp_q;
  assign bus.i_resp_rdata = rdata_q;
  assign bus.d_resp_rdata = rdata_q;
  assign dbg_state        = state_q;
endmodule
